debounced_updown_counter: RTL

//  Parametrised up/down event counter driven by two raw push-buttons (inc, dec).
//  Per-button: 2-FF synchroniser, integrating debouncer, rising-edge detector.

---
 rtl/debounced_updown_counter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/debounced_updown_counter.sv
// Up/down event counter fed by two raw push-buttons, each synchronised, debounced and edge-detected.
// Optional auto-repeat while a button is held: define COUNTER_AUTOREPEAT_EN.
module debounced_updown_counter #(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned MAX_VAL      = 15,
    parameter int unsigned DB_CYCLES    = 16,
    parameter int unsigned SATURATE     = 0,
    parameter int unsigned REPEAT_DELAY = 1000,
    parameter int unsigned REPEAT_RATE  = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_btn,
    input  logic             dec_btn,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             inc_evt,
    output logic             dec_evt,
    output logic             limit,
    output logic             at_max,
    output logic             at_min
);

    localparam int unsigned DBW = $clog2(DB_CYCLES);
    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    if (MAX_VAL == 0 || (MAX_VAL >> WIDTH) != 0 || DB_CYCLES < 2 ||
        REPEAT_DELAY == 0 || REPEAT_RATE == 0) begin : g_param_check
        $error("debounced_updown_counter: illegal parameter combination");
    end

    // Bit 0 carries the increment button, bit 1 the decrement button throughout.
    logic [1:0]          sync1_q, sync2_q;
    logic [1:0]          db_q, db_d, db_prev_q;
    logic [1:0][DBW-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]          press, opp_press, req;

    logic [WIDTH-1:0] count_q, count_d;
    logic             inc_evt_q, inc_evt_d;
    logic             dec_evt_q, dec_evt_d;
    logic             limit_q, limit_d;

    // Integrating debouncer: a level change must persist DB_CYCLES cycles.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] == db_q[b]) begin
                db_cnt_d[b] = '0;
            end else if (db_cnt_q[b] == DBW'(DB_CYCLES - 1)) begin
                db_d[b]     = ~db_q[b];
                db_cnt_d[b] = '0;
            end else begin
                db_cnt_d[b] = db_cnt_q[b] + DBW'(1);
            end
        end
    end

    assign press     = db_q & ~db_prev_q;
    assign opp_press = {press[0], press[1]};

`ifdef COUNTER_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RPW     = $clog2(RPT_MAX + 1);

    logic [1:0][RPW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [1:0]          rpt_run_q, rpt_run_d;
    logic [1:0]          rpt_first_q, rpt_first_d;
    logic [1:0]          rpt_fire;

    // Repeat timer counts cycles since the last applied step of a held button.
    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_run_d   = rpt_run_q;
        rpt_first_d = rpt_first_q;
        rpt_fire    = '0;
        for (int b = 0; b < 2; b++) begin
            rpt_fire[b] = rpt_run_q[b] && db_q[b] &&
                          (rpt_cnt_q[b] == (rpt_first_q[b] ? RPW'(REPEAT_DELAY) : RPW'(REPEAT_RATE)));
            if (clr || !db_q[b] || opp_press[b]) begin
                rpt_run_d[b] = 1'b0;
                rpt_cnt_d[b] = '0;
            end else if (press[b]) begin
                rpt_run_d[b]   = 1'b1;
                rpt_first_d[b] = 1'b1;
                rpt_cnt_d[b]   = RPW'(1);
            end else if (rpt_fire[b]) begin
                rpt_first_d[b] = 1'b0;
                rpt_cnt_d[b]   = RPW'(1);
            end else if (rpt_run_q[b]) begin
                rpt_cnt_d[b] = rpt_cnt_q[b] + RPW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q   <= '0;
            rpt_run_q   <= '0;
            rpt_first_q <= '0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_run_q   <= rpt_run_d;
            rpt_first_q <= rpt_first_d;
        end
    end

    assign req = press | rpt_fire;
`else
    assign req = press;
`endif

    // Step arbitration: clear wins, simultaneous inc/dec cancel, limits wrap or clamp.
    always_comb begin
        count_d   = count_q;
        inc_evt_d = 1'b0;
        dec_evt_d = 1'b0;
        limit_d   = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (req[0] ^ req[1]) begin
            if (req[0]) begin
                inc_evt_d = 1'b1;
                if (count_q == MAX_C) begin
                    limit_d = 1'b1;
                    if (SATURATE == 0) count_d = '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                dec_evt_d = 1'b1;
                if (count_q == '0) begin
                    limit_d = 1'b1;
                    if (SATURATE == 0) count_d = MAX_C;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            db_cnt_q  <= '0;
            count_q   <= '0;
            inc_evt_q <= 1'b0;
            dec_evt_q <= 1'b0;
            limit_q   <= 1'b0;
        end else begin
            sync1_q   <= {dec_btn, inc_btn};
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            db_cnt_q  <= db_cnt_d;
            count_q   <= count_d;
            inc_evt_q <= inc_evt_d;
            dec_evt_q <= dec_evt_d;
            limit_q   <= limit_d;
        end
    end

    assign count   = count_q;
    assign inc_evt = inc_evt_q;
    assign dec_evt = dec_evt_q;
    assign limit   = limit_q;
    assign at_max  = (count_q == MAX_C);
    assign at_min  = (count_q == '0);

endmodule
